// File: rtl/parity_frame_tx.sv
// Purpose : serialises one byte as start, 8 data bits LSB first, parity, stop.
// Latency : tx drops to 0 on the accept edge; a frame takes 11*CLKS_PER_BIT cycles.
// Backpr. : din_ready is high only in IDLE, so an offered byte waits until the line is free.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   din, din_valid, odd_sel / din_ready - byte offer (valid/ready) with parity mode
//   tx                    - registered serial line, idles high
//   busy, parity_bit, done - frame in progress, parity of the current or last frame,
//                            one-cycle pulse in the last cycle of the stop bit
module parity_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       odd_sel,
    output logic       tx,
    output logic       busy,
    output logic       parity_bit,
    output logic       done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;

    logic          bit_end;
    logic [2:0]    idx_nx;

    assign bit_end = (timer_q == LAST);
    assign idx_nx  = idx_q + 3'd1;

    assign din_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign parity_bit = par_q;
    // Qualified by rst_n so that a frame cut short by reset never reports completion.
    assign done       = rst_n && (state_q == STOP) && bit_end;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        tx_d    = tx_q;

        if (state_q == IDLE) begin
            timer_d = '0;
            idx_d   = 3'd0;
            tx_d    = 1'b1;
            if (din_valid) begin
                data_d  = din;
                // Even mode: XOR of the data; odd mode inverts it.
                par_d   = (^din) ^ odd_sel;
                state_d = START;
                tx_d    = 1'b0;
            end
        end else if (!bit_end) begin
            timer_d = timer_q + 1'b1;
        end else begin
            // Bit boundary: reload the timer and put the next bit on the line
            // in the same edge, so tx stays a pure register.
            timer_d = '0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end
                DATA: begin
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        idx_d = idx_nx;
                        tx_d  = data_q[idx_nx];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Purpose : directed check of parity_frame_tx at CLKS_PER_BIT=4 and 1.
// Latency : every frame is checked cycle by cycle against hand-built bit sequences.
// Backpr. : din_ready is checked low throughout each frame and high in IDLE.
module tb_parity_frame_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       odd_sel = 1'b0;
    logic       din_ready, tx, busy, parity_bit, done;

    logic [7:0] c1_din = 8'h00;
    logic       c1_valid = 1'b0;
    logic       c1_odd = 1'b0;
    logic       c1_ready, c1_tx, c1_busy, c1_par, c1_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .odd_sel(odd_sel), .tx(tx), .busy(busy),
        .parity_bit(parity_bit), .done(done)
    );

    parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(c1_din), .din_valid(c1_valid),
        .din_ready(c1_ready), .odd_sel(c1_odd), .tx(c1_tx), .busy(c1_busy),
        .parity_bit(c1_par), .done(c1_done)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // frame cycle 1 (the cycle right after the accept edge).
    task automatic offer(input logic [7:0] b, input logic odd);
        din       = b;
        odd_sel   = odd;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_tx"}, tx, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_rdy"}, din_ready, 1'b1);
        check({tag, "_idle_done"}, done, 1'b0);
    endtask

    // Entered at the negedge of frame cycle 1, leaves at the negedge of the
    // last frame cycle. frame[i] is the i-th transmitted bit (0 = start).
    // When chg_at is non-zero, din/odd_sel are disturbed at that cycle.
    task automatic check_frame(input string tag, input logic [10:0] frame,
                               input logic par, input int chg_at);
        for (int k = 1; k <= 11 * CPB; k++) begin
            if (k == chg_at) begin
                din     = 8'hFF;
                odd_sel = ~odd_sel;
            end
            check({tag, "_tx"}, tx, frame[(k - 1) / CPB]);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_rdy"}, din_ready, 1'b0);
            check({tag, "_done"}, done, (k == 11 * CPB));
            if (k == 1 || k == 11 * CPB)
                check({tag, "_par"}, parity_bit, par);
            if (k < 11 * CPB)
                @(negedge clk);
        end
    endtask

    initial begin
        logic seen_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdy", din_ready, 1'b1);
        check("rst_par", parity_bit, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5 even: 0,1,0,1,0,0,1,0,1,0,1, parity 0, done in cycle 44
        offer(8'hA5, 1'b0);
        din_valid = 1'b0;
        check_frame("a5_even", 11'b10_10100101_0, 1'b0, 0);
        @(negedge clk);
        check_idle("a5_even");

        // 0x07 (three ones): parity 1 in even mode, 0 in odd mode
        offer(8'h07, 1'b0);
        din_valid = 1'b0;
        check_frame("07_even", 11'b11_00000111_0, 1'b1, 0);
        @(negedge clk);
        check_idle("07_even");
        offer(8'h07, 1'b1);
        din_valid = 1'b0;
        check_frame("07_odd", 11'b10_00000111_0, 1'b0, 0);
        @(negedge clk);
        check_idle("07_odd");

        // Back-to-back with din_valid held: 0x3C then 0xC3, one idle cycle between
        offer(8'h3C, 1'b0);
        din = 8'hC3;
        check_frame("b2b_3c", 11'b10_00111100_0, 1'b0, 0);
        @(negedge clk);
        check_idle("b2b_gap");
        @(negedge clk);
        din_valid = 1'b0;
        check_frame("b2b_c3", 11'b10_11000011_0, 1'b0, 0);
        @(negedge clk);
        check_idle("b2b_c3");

        // 0x5A odd (parity 1); din and odd_sel disturbed mid-frame
        offer(8'h5A, 1'b1);
        din_valid = 1'b0;
        check_frame("midchg", 11'b11_01011010_0, 1'b1, 20);
        @(negedge clk);
        check_idle("midchg");

        // Reset during DATA aborts the frame
        offer(8'h07, 1'b0);
        din_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_rdy", din_ready, 1'b1);
        check("abort_par", parity_bit, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            seen_done = seen_done | done | busy;
            @(negedge clk);
        end
        check("abort_quiet", seen_done, 1'b0);
        offer(8'h07, 1'b1);
        din_valid = 1'b0;
        check_frame("after_abort", 11'b10_00000111_0, 1'b0, 0);
        @(negedge clk);
        check_idle("after_abort");

        // Reset wins over an accept on the same edge
        din       = 8'h00;
        din_valid = 1'b1;
        rst_n     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b1;
        check("rst_prio_busy", busy, 1'b0);
        check("rst_prio_tx", tx, 1'b1);
        @(negedge clk);
        check("rst_prio_busy2", busy, 1'b0);

        // CLKS_PER_BIT=1: 0x80 odd -> 0,0,0,0,0,0,0,0,1,0,1
        begin
            logic [10:0] f1;
            f1       = 11'b10_10000000_0;
            c1_din   = 8'h80;
            c1_odd   = 1'b1;
            c1_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            c1_valid = 1'b0;
            for (int k = 1; k <= 11; k++) begin
                check("cpb1_tx", c1_tx, f1[k - 1]);
                check("cpb1_busy", c1_busy, 1'b1);
                check("cpb1_done", c1_done, (k == 11));
                if (k < 11)
                    @(negedge clk);
            end
            check("cpb1_par", c1_par, 1'b0);
            @(negedge clk);
            check("cpb1_idle_busy", c1_busy, 1'b0);
            check("cpb1_idle_tx", c1_tx, 1'b1);
            check("cpb1_idle_rdy", c1_ready, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
